gcd_job_sequencer: RTL and testbench

Command-queue front end for the sequential GCD engine in the user project. It accepts operand pairs from the Wishbone/LA control side through a valid/ready handshake and buffers them in a small FIFO. It issues them one at a time to the engine with a start/done handshake, then holds each result in an output register until the consumer takes it. Pairs with a zero operand bypass the engine.

---
 rtl/gcd_job_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_gcd_job_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_job_sequencer.sv
// Command FIFO + issue FSM in front of a sequential GCD engine; zero-operand pairs bypass the engine.
// Optional engine watchdog enabled by defining GCD_SEQ_TIMEOUT_EN.
module gcd_job_sequencer #(
  parameter int BITS    = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid_i,
  input  logic [BITS-1:0]          cmd_a_i,
  input  logic [BITS-1:0]          cmd_b_i,
  output logic                     cmd_ready_o,
  output logic                     eng_start_o,
  output logic [BITS-1:0]          eng_a_o,
  output logic [BITS-1:0]          eng_b_o,
  input  logic                     eng_done_i,
  input  logic [BITS-1:0]          eng_result_i,
  output logic                     res_valid_o,
  output logic [BITS-1:0]          res_data_o,
  output logic                     res_err_o,
  input  logic                     res_ready_i,
  output logic [$clog2(DEPTH):0]   cmd_level_o,
  output logic                     busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  // Pointer wrap relies on a power-of-two depth; reject bad configurations at elaboration.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("gcd_job_sequencer: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("gcd_job_sequencer: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  // Command FIFO storage and bookkeeping
  logic [2*BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     count_q, count_d;

  // FSM and registered outputs
  state_e            state_q;
  logic              eng_start_q;
  logic [BITS-1:0]   eng_a_q, eng_b_q;
  logic              res_valid_q;
  logic [BITS-1:0]   res_data_q;

`ifdef GCD_SEQ_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  logic [WDW-1:0]    wd_cnt_q;
  logic              res_err_q;
`endif

  logic              push;
  logic              pop;
  logic              res_pop;
  logic [BITS-1:0]   head_a, head_b;
  logic              head_zero;

  assign cmd_ready_o = (count_q != LEVEL_FULL);
  assign push        = cmd_valid_i && cmd_ready_o;
  // Only one job in flight: the head leaves the FIFO only when idle and the result slot is empty.
  assign pop         = (state_q == S_IDLE) && (count_q != '0) && !res_valid_q;
  assign res_pop     = res_valid_q && res_ready_i;

  assign head_a      = mem_q[rd_ptr_q][2*BITS-1:BITS];
  assign head_b      = mem_q[rd_ptr_q][BITS-1:0];
  assign head_zero   = (head_a == '0) || (head_b == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset: contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_a_i, cmd_b_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      eng_start_q <= 1'b0;
      eng_a_q     <= '0;
      eng_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
`ifdef GCD_SEQ_TIMEOUT_EN
      wd_cnt_q    <= '0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      eng_start_q <= 1'b0;
      if (res_pop) res_valid_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            if (head_zero) begin
              // gcd(x,0) = x and gcd(0,0) = 0, so OR-ing covers every zero case.
              res_data_q  <= head_a | head_b;
              res_valid_q <= 1'b1;
`ifdef GCD_SEQ_TIMEOUT_EN
              res_err_q   <= 1'b0;
`endif
            end else begin
              eng_a_q     <= head_a;
              eng_b_q     <= head_b;
              eng_start_q <= 1'b1;
              state_q     <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          state_q <= S_WAIT;
`ifdef GCD_SEQ_TIMEOUT_EN
          wd_cnt_q <= '0;
`endif
        end

        S_WAIT: begin
          if (eng_done_i) begin
            res_data_q  <= eng_result_i;
            res_valid_q <= 1'b1;
            state_q     <= S_IDLE;
`ifdef GCD_SEQ_TIMEOUT_EN
            res_err_q   <= 1'b0;
          end else if (wd_cnt_q == WD_LAST) begin
            // Edge closing the TIMEOUT-th silent WAIT cycle: abort with an error result.
            res_data_q  <= '0;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            wd_cnt_q    <= wd_cnt_q + 1'b1;
`endif
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign eng_start_o = eng_start_q;
  assign eng_a_o     = eng_a_q;
  assign eng_b_o     = eng_b_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign cmd_level_o = count_q;
  assign busy_o      = (state_q != S_IDLE) || (count_q != '0);

`ifdef GCD_SEQ_TIMEOUT_EN
  assign res_err_o   = res_err_q;
`else
  assign res_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Self-checking bench for gcd_job_sequencer: directed steps plus random jobs against a queue-based model.
// Honours GCD_SEQ_TIMEOUT_EN the same way as the design.
module tb_gcd_job_sequencer;
  localparam int BITS  = 32;
  localparam int DEPTH = 4;
  localparam int TOUT  = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   cmd_valid_i;
  logic [BITS-1:0]        cmd_a_i, cmd_b_i;
  logic                   cmd_ready_o;
  logic                   eng_start_o;
  logic [BITS-1:0]        eng_a_o, eng_b_o;
  logic                   eng_done_i;
  logic [BITS-1:0]        eng_result_i;
  logic                   res_valid_o;
  logic [BITS-1:0]        res_data_o;
  logic                   res_err_o;
  logic                   res_ready_i;
  logic [$clog2(DEPTH):0] cmd_level_o;
  logic                   busy_o;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected results in command order: {err, data}
  logic [BITS:0] exp_q[$];

  bit            eng_silent  = 1'b0;
  bit            manual_done = 1'b0;
  int            eng_lat     = 5;
  int            eng_cd      = -1;
  int            start_cnt   = 0;
  logic [BITS-1:0] ea = '0, eb = '0;

  always #5 clk = ~clk;

  gcd_job_sequencer #(.BITS(BITS), .DEPTH(DEPTH), .TIMEOUT(TOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_a_i      (cmd_a_i),
    .cmd_b_i      (cmd_b_i),
    .cmd_ready_o  (cmd_ready_o),
    .eng_start_o  (eng_start_o),
    .eng_a_o      (eng_a_o),
    .eng_b_o      (eng_b_o),
    .eng_done_i   (eng_done_i),
    .eng_result_i (eng_result_i),
    .res_valid_o  (res_valid_o),
    .res_data_o   (res_data_o),
    .res_err_o    (res_err_o),
    .res_ready_i  (res_ready_i),
    .cmd_level_o  (cmd_level_o),
    .busy_o       (busy_o)
  );

  function automatic logic [BITS-1:0] gcd_ref(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    logic [BITS-1:0] t;
    if (a == '0 || b == '0) return a | b;
    while (b != '0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Engine model: answers gcd(a,b) eng_lat cycles after the start pulse unless silenced.
  initial begin
    eng_done_i   = 1'b0;
    eng_result_i = '0;
    forever begin
      @(negedge clk);
      if (eng_cd == 0) begin
        check("eng_a_stable", eng_a_o, ea);
        check("eng_b_stable", eng_b_o, eb);
        eng_done_i   = 1'b1;
        eng_result_i = gcd_ref(ea, eb);
        eng_cd       = -1;
      end else begin
        eng_done_i = manual_done;
        if (manual_done) eng_result_i = 32'h0BAD_F00D;
        if (eng_cd > 0) eng_cd--;
      end
      if (eng_start_o === 1'b1) begin
        start_cnt++;
        ea = eng_a_o;
        eb = eng_b_o;
        if (!eng_silent) eng_cd = eng_lat - 1;
      end
    end
  end

  task automatic push_try(input logic [BITS-1:0] a, input logic [BITS-1:0] b, output bit acc);
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_a_i     = a;
    cmd_b_i     = b;
    acc         = cmd_ready_o;
    if (acc) exp_q.push_back({1'b0, gcd_ref(a, b)});
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic collect(input int bound);
    logic [BITS:0] exp;
    int w;
    w = 0;
    @(negedge clk);
    while (res_valid_o !== 1'b1 && w < bound) begin
      @(negedge clk);
      w++;
    end
    check("res_arrives", res_valid_o, 1'b1);
    if (res_valid_o === 1'b1) begin
      check("res_expected", exp_q.size() > 0, 1'b1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check("res_data", res_data_o, exp[BITS-1:0]);
      check("res_err", res_err_o, exp[BITS]);
      res_ready_i = 1'b1;
      @(posedge clk);
      #1;
      res_ready_i = 1'b0;
      check("res_clear", res_valid_o, 1'b0);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) collect(200);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic wait_start(input int bound);
    int w;
    w = 0;
    @(negedge clk);
    while (eng_start_o !== 1'b1 && w < bound) begin
      @(negedge clk);
      w++;
    end
    check("start_seen", eng_start_o, 1'b1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  function automatic logic [BITS-1:0] rand_op();
    if ($urandom_range(0, 3) == 0) return '0;
    return BITS'($urandom_range(1, 40) * $urandom_range(1, 500));
  endfunction

  initial begin
    bit acc;
    int snap, tries;
    logic [BITS-1:0] ra, rb;

    rst_n       = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_a_i     = '0;
    cmd_b_i     = '0;
    res_ready_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", cmd_ready_o, 1'b1);
    check("rst_level", cmd_level_o, 0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_valid", res_valid_o, 1'b0);
    check("rst_data", res_data_o, 0);
    check("rst_err", res_err_o, 1'b0);
    check("rst_start", eng_start_o, 1'b0);
    check("rst_eng_a", eng_a_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single engine job (48,18) with exact issue latency
    eng_lat = 5;
    push_try(32'd48, 32'd18, acc);
    check("t1_accept", acc, 1'b1);
    @(negedge clk);
    check("t1_start_early", eng_start_o, 1'b0);
    check("t1_level_1", cmd_level_o, 1);
    @(negedge clk);
    check("t1_start", eng_start_o, 1'b1);
    check("t1_level_0", cmd_level_o, 0);
    check("t1_busy", busy_o, 1'b1);
    check("t1_eng_a", eng_a_o, 48);
    check("t1_eng_b", eng_b_o, 18);
    collect(50);
    check("t1_starts", start_cnt, 1);

    // Back-pressure: 6 pushes with the consumer stalled, exactly 5 fit
    eng_lat = $urandom_range(1, 8);
    for (int i = 0; i < 6; i++) begin
      ra = BITS'($urandom_range(1, 30) * $urandom_range(1, 900));
      rb = BITS'($urandom_range(1, 30) * $urandom_range(1, 900));
      push_try(ra, rb, acc);
      check("t2_fill_accept", acc, i < 5);
    end
    check("t2_level_full", cmd_level_o, DEPTH);
    check("t2_ready_low", cmd_ready_o, 1'b0);
    collect(100);
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 10) begin
      push_try(ra, rb, acc);
      tries++;
    end
    check("t2_sixth_accept", acc, 1'b1);
    drain();

    // Zero-operand bypass
    snap = start_cnt;
    push_try(32'd0, 32'd35, acc);
    push_try(32'd0, 32'd0, acc);
    drain();
    repeat (3) @(negedge clk);
    check("t3_no_start", start_cnt, snap);

    // Simultaneous push and pop at level 2 keeps level and order
    eng_lat = $urandom_range(1, 6);
    push_try(32'd91, 32'd65, acc);
    push_try(32'd0, 32'd77, acc);
    push_try(32'd120, 32'd84, acc);
    tries = 0;
    while (res_valid_o !== 1'b1 && tries < 100) begin
      @(negedge clk);
      tries++;
    end
    check("t6_level_2", cmd_level_o, 2);
    collect(10);
    push_try(32'd1000, 32'd250, acc);
    check("t6_push_accept", acc, 1'b1);
    check("t6_level_same", cmd_level_o, 2);
    drain();

    // Reset during WAIT, then a late eng_done
    eng_silent = 1'b1;
    push_try(32'd30, 32'd12, acc);
    wait_start(20);
    push_try(32'd7, 32'd0, acc);
    push_try(32'd9, 32'd3, acc);
    check("t4_level_pre", cmd_level_o, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4_level", cmd_level_o, 0);
    check("t4_ready", cmd_ready_o, 1'b1);
    check("t4_busy", busy_o, 1'b0);
    check("t4_valid", res_valid_o, 1'b0);
    check("t4_start", eng_start_o, 1'b0);
    check("t4_eng_b", eng_b_o, 0);
    exp_q.delete();
    snap = start_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 manual_done = 1'b1;
    @(posedge clk);
    #1 manual_done = 1'b0;
    repeat (10) @(negedge clk);
    check("t4_no_result", res_valid_o, 1'b0);
    check("t4_data_zero", res_data_o, 0);
    check("t4_idle", busy_o, 1'b0);
    check("t4_no_start", start_cnt, snap);

    // Silent engine: watchdog abort, or indefinite wait without it
    push_try(32'd100, 32'd75, acc);
    wait_start(20);
    @(posedge clk);
`ifdef GCD_SEQ_TIMEOUT_EN
    void'(exp_q.pop_back());
    exp_q.push_back({1'b1, {BITS{1'b0}}});
    repeat (TOUT - 1) @(posedge clk);
    #1;
    check("t5_not_yet", res_valid_o, 1'b0);
    @(posedge clk);
    #1;
    check("t5_valid", res_valid_o, 1'b1);
    check("t5_data", res_data_o, 0);
    check("t5_err", res_err_o, 1'b1);
    collect(5);
`else
    repeat (1000) @(posedge clk);
    #1;
    check("t5_no_result", res_valid_o, 1'b0);
    check("t5_still_busy", busy_o, 1'b1);
    pulse_reset();
`endif
    eng_silent = 1'b0;
    push_try(32'd21, 32'd14, acc);
    drain();

    // Random jobs with random consumer timing
    for (int i = 0; i < 24; i++) begin
      eng_lat = $urandom_range(1, 8);
      ra = rand_op();
      rb = rand_op();
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 50) begin
        push_try(ra, rb, acc);
        if (!acc && res_valid_o === 1'b1) collect(5);
        tries++;
      end
      check("rnd_accept", acc, 1'b1);
      if ($urandom_range(0, 1) == 1 && res_valid_o === 1'b1) collect(5);
    end
    drain();
    repeat (3) @(negedge clk);
    check("end_idle", busy_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
